ref_fetch: RTL

Reference-window fetch controller for the motion-estimation datapath. On a start request it walks a rectangular search window of the reference frame row by row, drives byte addresses and read enable into the reference frame memory (combinational, 64-bit big-endian words: byte at `addr` lands in bits [63:56]), and captures each returned word into a small FIFO. The FIFO feeds the downstream search-window buffer / PE array over a valid/ready stream, with row and window markers.

---
 rtl/ref_fetch_if.sv | 21 ++
 rtl/ref_fetch.sv | 117 +++++++++++
 2 files changed

// File: rtl/ref_fetch_if.sv
// ref_fetch_if: reference-memory read port and output word stream of the window fetcher.
interface ref_fetch_if;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_data;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_eol;
    logic        out_last;

    modport master (
        output mem_en, mem_addr, out_data, out_valid, out_eol, out_last,
        input  mem_data, out_ready
    );

    modport slave (
        input  mem_en, mem_addr, out_data, out_valid, out_eol, out_last,
        output mem_data, out_ready
    );
endinterface

// File: rtl/ref_fetch.sv
// ref_fetch: walks a rectangular reference window row by row, reading 64-bit words
// into a small FIFO that streams them downstream with row/window markers.
module ref_fetch #(
    parameter int WORDS_PER_ROW = 8,
    parameter int ROWS          = 64,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  base_addr,
    input  logic [15:0]  stride,
    ref_fetch_if.master  bus,
    output logic         busy,
    output logic         done
);
    localparam int CW = WORDS_PER_ROW > 1 ? $clog2(WORDS_PER_ROW) : 1;
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [31:0]     row_base_q, row_base_d;
    logic [31:0]     cur_addr_q, cur_addr_d;
    logic [15:0]     stride_q, stride_d;
    logic [65:0]     fifo_q [FIFO_DEPTH];
    logic [65:0]     fifo_d [FIFO_DEPTH];
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            head_v, pop, issue, eol, last;

    // FIFO entry layout: {last, eol, data}
    always_comb begin
        head_v     = cnt_q != '0;
        pop        = head_v && bus.out_ready;
        issue      = (state_q == FETCH) && (!cnt_q[AW] || pop);
        eol        = col_q == CW'(WORDS_PER_ROW - 1);
        last       = eol && (row_q == RW'(ROWS - 1));
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        cur_addr_d = cur_addr_q;
        stride_d   = stride_q;
        fifo_d     = fifo_q;
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        wr_d       = issue ? wr_q + 1'b1 : wr_q;
        cnt_d      = cnt_q + (AW+1)'(issue) - (AW+1)'(pop);
        done_d     = 1'b0;
        if (state_q == IDLE && start) begin
            state_d    = FETCH;
            col_d      = '0;
            row_d      = '0;
            row_base_d = base_addr;
            cur_addr_d = base_addr;
            stride_d   = stride;
        end
        if (issue) begin
            fifo_d[wr_q] = {last, eol, bus.mem_data};
            if (eol) begin
                col_d      = '0;
                row_d      = row_q + 1'b1;
                row_base_d = row_base_q + {16'h0, stride_q};
                cur_addr_d = row_base_d;
            end else begin
                col_d      = col_q + 1'b1;
                cur_addr_d = cur_addr_q + 32'd8;
            end
            if (last) state_d = DRAIN;
        end
        if (state_q == DRAIN && pop && fifo_q[rd_q][65]) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            cur_addr_q <= '0;
            stride_q   <= '0;
            fifo_q     <= '{default: '0};
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            cur_addr_q <= cur_addr_d;
            stride_q   <= stride_d;
            fifo_q     <= fifo_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_en    = issue;
    assign bus.mem_addr  = issue ? cur_addr_q : '0;
    assign bus.out_valid = head_v;
    assign bus.out_data  = head_v ? fifo_q[rd_q][63:0] : '0;
    assign bus.out_eol   = head_v && fifo_q[rd_q][64];
    assign bus.out_last  = head_v && fifo_q[rd_q][65];
    assign busy          = state_q != IDLE;
    assign done          = done_q;
endmodule
